// File: rtl/led_blink_ctrl.sv
// Command-driven LED sequencer: OFF / ON / BLINK / counted BURST, paced by a tick prescaler.
// Optional PWM dimming of the ON level is enabled by defining LED_DIM_EN (adds dim_level input).
module led_blink_ctrl #(
    parameter int TICK_CYCLES = 16777216,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
`ifdef LED_DIM_EN
    input  logic [3:0]       dim_level,
`endif
    output logic             busy,
    output logic             done,
    output logic             led,
    output logic [2:0]       dbg_state
);

    localparam int PW = $clog2(TICK_CYCLES);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_ON        = 3'd1,
        S_BLINK     = 3'd2,
        S_BURST_ON  = 3'd3,
        S_BURST_OFF = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_mode/cmd_count are sampled only then, and the requester holds valid while busy.
    state_t           state, state_d;
    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             led_q, led_d;
    logic             tick;
    logic             accept;

    assign tick      = (pre == PW'(TICK_CYCLES - 1));
    assign busy      = (state == S_BURST_ON) || (state == S_BURST_OFF) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign cmd_ready = !busy;
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;

    // Prescaler free-runs in every state; acceptance restarts the phase timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (accept || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
            cnt   <= '0;
            led_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            led_q <= led_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        led_d   = led_q;
        case (state)
            S_OFF, S_ON, S_BLINK: begin
                if (accept) begin
                    case (cmd_mode)
                        2'd0: begin
                            state_d = S_OFF;
                            led_d   = 1'b0;
                        end
                        2'd1: begin
                            state_d = S_ON;
                            led_d   = 1'b1;
                        end
                        2'd2: begin
                            state_d = S_BLINK;
                            led_d   = 1'b1;
                        end
                        default: begin
                            if (cmd_count != '0) begin
                                state_d = S_BURST_ON;
                                led_d   = 1'b1;
                                cnt_d   = cmd_count;
                            end else begin
                                state_d = S_DONE;
                                led_d   = 1'b0;
                            end
                        end
                    endcase
                end else if (state == S_BLINK && tick) begin
                    led_d = !led_q;
                end
            end
            S_BURST_ON: begin
                if (tick) begin
                    state_d = S_BURST_OFF;
                    led_d   = 1'b0;
                    cnt_d   = cnt - CNT_W'(1);
                end
            end
            S_BURST_OFF: begin
                // Counter was decremented on entry, so zero here means the last ON phase is done.
                if (tick) begin
                    if (cnt != '0) begin
                        state_d = S_BURST_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_OFF;
                led_d   = 1'b0;
            end
            default: begin
                state_d = S_OFF;
                led_d   = 1'b0;
            end
        endcase
    end

`ifdef LED_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign led = led_q && (pwm_cnt <= dim_level);
`else
    assign led = led_q;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl with TICK_CYCLES=4: vector table plus hand-written
// sequences for BLINK restart, BURST (held command, zero, maximum count) and mid-burst reset.
module tb_led_blink_ctrl;

    localparam int TICK  = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_mode = 2'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             busy;
    logic             done;
    logic             led;
    logic [2:0]       dbg_state;

    led_blink_ctrl #(.TICK_CYCLES(TICK), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .busy      (busy),
        .done      (done),
        .led       (led),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Expected outputs are packed as {led, busy, done, cmd_ready}.
    typedef struct packed {
        logic             v;
        logic [1:0]       mode;
        logic [CNT_W-1:0] cnt;
        logic [3:0]       exp_out;
    } vec_t;

    vec_t       tbl[16];
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic compare_out(input string name);
        logic [3:0] got;
        logic [3:0] want;
        got = {led, busy, done, cmd_ready};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got led/busy/done/ready=%b at %0t", name, got, $time);
        end else begin
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got led/busy/done/ready=%b, expected %b at %0t",
                         name, got, want, $time);
            end
        end
    endtask

    task automatic check_now(input logic [3:0] e, input string name);
        exp_q.push_back(e);
        compare_out(name);
    endtask

    // Drive one cycle of inputs, then compare the outputs seen after the capturing edge.
    task automatic step(input logic v, input logic [1:0] mode, input logic [CNT_W-1:0] count,
                        input logic [3:0] e, input string name);
        cmd_valid = v;
        cmd_mode  = mode;
        cmd_count = count;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(name);
    endtask

    function automatic logic phase_on(input int i);
        return ((i / TICK) % 2) == 0;
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 2'd1, 4'd0, 4'b1001};  // ON accepted
        tbl[1]  = '{1'b0, 2'd0, 4'd0, 4'b1001};
        tbl[2]  = '{1'b0, 2'd0, 4'd0, 4'b1001};
        tbl[3]  = '{1'b1, 2'd0, 4'd0, 4'b0001};  // OFF accepted
        tbl[4]  = '{1'b0, 2'd0, 4'd0, 4'b0001};
        tbl[5]  = '{1'b1, 2'd1, 4'd7, 4'b1001};  // ON, count ignored
        tbl[6]  = '{1'b1, 2'd1, 4'd0, 4'b1001};  // ON re-issued
        tbl[7]  = '{1'b1, 2'd2, 4'd0, 4'b1001};  // BLINK starts in ON phase
        tbl[8]  = '{1'b0, 2'd0, 4'd0, 4'b1001};
        tbl[9]  = '{1'b1, 2'd0, 4'd0, 4'b0001};  // OFF preempts BLINK
        tbl[10] = '{1'b0, 2'd0, 4'd0, 4'b0001};
        tbl[11] = '{1'b1, 2'd2, 4'd0, 4'b1001};
        tbl[12] = '{1'b1, 2'd1, 4'd0, 4'b1001};  // ON preempts BLINK
        tbl[13] = '{1'b0, 2'd0, 4'd0, 4'b1001};
        tbl[14] = '{1'b1, 2'd0, 4'd0, 4'b0001};
        tbl[15] = '{1'b0, 2'd0, 4'd0, 4'b0001};

        // Reset state
        #1;
        check_now(4'b0001, "reset_outputs");
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d, expected 0 (S_OFF)", dbg_state);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 20; i++) step(1'b0, 2'd0, '0, 4'b0001, "idle");

        for (int i = 0; i < 16; i++)
            step(tbl[i].v, tbl[i].mode, tbl[i].cnt, tbl[i].exp_out, $sformatf("tbl[%0d]", i));

        // BLINK pattern 1111 0000 ..., then re-issue in the middle of an OFF phase
        step(1'b1, 2'd2, '0, 4'b1001, "blink_acc");
        for (int i = 1; i < 22; i++) step(1'b0, 2'd0, '0, {phase_on(i), 3'b001}, "blink_pat");
        step(1'b1, 2'd2, '0, 4'b1001, "blink_reissue");
        for (int i = 1; i < 8; i++) step(1'b0, 2'd0, '0, {phase_on(i), 3'b001}, "blink_restart");

        // BURST of 3 with an ON command held valid the whole time
        step(1'b1, 2'd3, 4'd3, 4'b1100, "burst3_acc");
        for (int i = 1; i < 24; i++) step(1'b1, 2'd1, '0, {phase_on(i), 3'b100}, "burst3_pat");
        step(1'b1, 2'd1, '0, 4'b0110, "burst3_done");
        step(1'b1, 2'd1, '0, 4'b0001, "burst3_ready");
        step(1'b1, 2'd1, '0, 4'b1001, "held_on_acc");
        step(1'b0, 2'd0, '0, 4'b1001, "held_on_stay");

        // BURST of 0: straight to the done pulse
        step(1'b1, 2'd3, 4'd0, 4'b0110, "burst0_done");
        step(1'b0, 2'd0, '0, 4'b0001, "burst0_ready");
        step(1'b0, 2'd0, '0, 4'b0001, "burst0_idle");

        // Maximum burst count: 15 ON phases
        step(1'b1, 2'd3, 4'd15, 4'b1100, "burst15_acc");
        for (int i = 1; i < 120; i++) step(1'b0, 2'd0, '0, {phase_on(i), 3'b100}, "burst15_pat");
        step(1'b0, 2'd0, '0, 4'b0110, "burst15_done");
        step(1'b0, 2'd0, '0, 4'b0001, "burst15_ready");

        // Reset during the second ON phase of a burst
        step(1'b1, 2'd3, 4'd3, 4'b1100, "burst_rst_acc");
        for (int i = 1; i < 10; i++) step(1'b0, 2'd0, '0, {phase_on(i), 3'b100}, "burst_rst_pat");
        #2 rst = 1'b1;
        #1 check_now(4'b0001, "rst_async");
        @(posedge clk);
        #1 check_now(4'b0001, "rst_hold");
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, '0, 4'b0001, "post_rst_idle");
        step(1'b1, 2'd2, '0, 4'b1001, "post_rst_blink");
        for (int i = 1; i < 12; i++) step(1'b0, 2'd0, '0, {phase_on(i), 3'b001}, "post_rst_pat");

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
